// File: rtl/lfsr_stream_cracker.sv
// lfsr_stream_cracker
//   Recovers the LFSR seed and tap pattern of an encrypted byte stream from
//   its PAD_CHAR preamble (all NUM_PTRN candidates checked in parallel), then
//   decrypts the remainder, strips leading PAD_CHAR bytes and emits plaintext
//   over valid/ready.
//
// Ports
//   clk, init_n            clock, async active-low reset
//   start, abort           begin message (from IDLE) / sync return to IDLE
//   in_data/valid/last     encrypted byte stream, in_ready back-pressures it
//   out_data/valid/last    plaintext stream, out_ready from the sink
//   busy, done             not-IDLE, one-cycle end-of-message pulse
//   found, err             sticky status until next start/abort/reset
//   ptrn_idx, seed         identified tap pattern and initial LFSR state

// One candidate tap pattern: next LFSR state and preamble match for this byte.
module lfsr_stream_cracker_lane #(
  parameter int                DATA_W   = 8,
  parameter int                LFSR_W   = 6,
  parameter logic [LFSR_W-1:0] PTRN     = '0,
  parameter logic [DATA_W-1:0] PAD_CHAR = 8'h5F
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [LFSR_W-1:0] nxt_o,
  output logic              match_o
);
  assign nxt_o   = {state_i[LFSR_W-2:0], ^(state_i & PTRN)};
  // keystream is the zero-extended state
  assign match_o = ((data_i ^ DATA_W'(nxt_o)) == PAD_CHAR);
endmodule

module lfsr_stream_cracker #(
  parameter int                         DATA_W    = 8,
  parameter int                         LFSR_W    = 6,
  parameter int                         NUM_PTRN  = 6,
  parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_LIST = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
  parameter logic [DATA_W-1:0]          PAD_CHAR  = 8'h5F,
  parameter int                         PRE_CHK   = 6,
  parameter int                         MAX_LEN   = 64
) (
  input  logic                        clk,
  input  logic                        init_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic                        err,
  output logic [$clog2(NUM_PTRN)-1:0] ptrn_idx,
  output logic [LFSR_W-1:0]           seed
);
  localparam int IDX_W = $clog2(NUM_PTRN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DECRYPT, S_FLUSH, S_DRAIN} state_e;

  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_PTRN-1:0][LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic [NUM_PTRN-1:0]             alive_q, alive_d, lane_match;
  logic [LFSR_W-1:0]               seed_c, seed_c_q, seed_q, key_sel;
  logic [IDX_W-1:0]                ptrn_idx_q, sel_idx;
  logic                            any_alive, byte0_ok, strip_q, is_last, accept, drop;
  logic [DATA_W-1:0]               pt, out_data_q;
  logic                            out_valid_q, out_last_q, done_q, found_q, err_q;

  for (genvar p = 0; p < NUM_PTRN; p++) begin : g_lane
    lfsr_stream_cracker_lane #(
      .DATA_W  (DATA_W),
      .LFSR_W  (LFSR_W),
      .PTRN    (PTRN_LIST[p*LFSR_W +: LFSR_W]),
      .PAD_CHAR(PAD_CHAR)
    ) u_lane (
      .state_i(lfsr_q[p]),
      .data_i (in_data),
      .nxt_o  (lfsr_nxt[p]),
      .match_o(lane_match[p])
    );
  end

  // Byte 0 fixes the seed's low bits; only the upper bits can disqualify it.
  assign seed_c   = in_data[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0];
  assign byte0_ok = ((in_data ^ DATA_W'(seed_c)) == PAD_CHAR);
  assign alive_d  = (cnt_q == '0) ? {NUM_PTRN{byte0_ok}} : (alive_q & lane_match);

  // Lowest surviving pattern wins.
  always_comb begin
    sel_idx   = '0;
    any_alive = 1'b0;
    for (int p = NUM_PTRN - 1; p >= 0; p--) begin
      if (alive_d[p]) begin
        sel_idx   = IDX_W'(p);
        any_alive = 1'b1;
      end
    end
  end

  always_comb begin
    key_sel = '0;
    for (int p = 0; p < NUM_PTRN; p++)
      if (IDX_W'(p) == ptrn_idx_q) key_sel = lfsr_nxt[p];
  end

  assign pt      = in_data ^ DATA_W'(key_sel);
  assign drop    = strip_q && (pt == PAD_CHAR);
  // Reaching MAX_LEN ends the message exactly like in_last.
  assign is_last = in_last || (cnt_q >= CNT_W'(MAX_LEN - 1));
  assign cnt_d   = (cnt_q == CNT_W'(MAX_LEN)) ? cnt_q : cnt_q + 1'b1;

  // abort gates acceptance so no byte is consumed on the abort cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!abort) begin
      case (state_q)
        S_PRE, S_DRAIN: in_ready = 1'b1;
        S_DECRYPT:      in_ready = !out_valid_q || out_ready;
        default:        in_ready = 1'b0;
      endcase
    end
  end
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= '0;
      alive_q     <= '0;
      seed_c_q    <= '0;
      seed_q      <= '0;
      ptrn_idx_q  <= '0;
      strip_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (abort) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        found_q     <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            found_q    <= 1'b0;
            err_q      <= 1'b0;
            ptrn_idx_q <= '0;
            seed_q     <= '0;
            cnt_q      <= '0;
            alive_q    <= '0;
            strip_q    <= 1'b1;
            state_q    <= S_PRE;
          end
          S_PRE: if (accept) begin
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
            for (int p = 0; p < NUM_PTRN; p++)
              lfsr_q[p] <= (cnt_q == '0) ? seed_c : lfsr_nxt[p];
            if (cnt_q == '0) seed_c_q <= seed_c;
            if (is_last) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (cnt_q == CNT_W'(PRE_CHK - 1)) begin
              if (any_alive) begin
                found_q    <= 1'b1;
                ptrn_idx_q <= sel_idx;
                seed_q     <= seed_c_q;
                state_q    <= S_DECRYPT;
              end else begin
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end
            end
          end
          S_DECRYPT: if (accept) begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_nxt;
            if (!drop) begin
              strip_q     <= 1'b0;
              out_data_q  <= pt;
              out_valid_q <= 1'b1;
              out_last_q  <= is_last;
            end
            if (is_last) state_q <= S_FLUSH;
          end
          // Hold off done until the final plaintext byte has left.
          S_FLUSH: if (!out_valid_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          S_DRAIN: if (accept) begin
            cnt_q <= cnt_d;
            if (is_last) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign ptrn_idx  = ptrn_idx_q;
  assign seed      = seed_q;

endmodule
